jstk_conditioner: RTL

Conditions the raw 40-bit PmodJSTK response into filtered joystick positions and a debounced fire event. Sits between the PmodJSTK SPI interface (DOUT) and the joystick parser/map logic: one instance per player, clocked in the VGA clock domain. Captures a new sample on each send/receive request edge, then runs a moving average, centre deadzone and fire debounce. Emits a one-cycle strobe when fresh outputs are valid.

---
 rtl/jstk_conditioner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/jstk_conditioner.sv
// rtl/jstk_conditioner.sv - PmodJSTK sample conditioner: moving average, deadzone, fire debounce
//
// Captures one PmodJSTK DOUT word per rising edge of sndRec. Each capture is
// averaged over the last N samples, snapped to CENTER inside the deadzone, and
// the fire bit is debounced. Fresh outputs are flagged by a one-cycle strobe.
//
// Ports:
//   clk          system clock (VGA clock domain)
//   reset        asynchronous, active-high reset
//   sndRec       send/receive request level; each rising edge requests a capture
//   jstk_data    40-bit PmodJSTK DOUT word
//   x_pos        filtered X position
//   y_pos        filtered Y position
//   fire_level   debounced fire button state
//   fire_pulse   one-cycle pulse on debounced fire 0->1
//   sample_valid one-cycle pulse when the outputs have just updated
module jstk_conditioner #(
  parameter int AVG_LOG2 = 2,
  parameter int CENTER   = 512,
  parameter int DEADZONE = 64,
  parameter int DEBOUNCE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sndRec,
  input  logic [39:0] jstk_data,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        fire_level,
  output logic        fire_pulse,
  output logic        sample_valid
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 10 + AVG_LOG2;
  localparam logic [9:0]    CENTER_W = 10'(CENTER);
  localparam logic [SW-1:0] SUM_RST  = SW'(CENTER * N);

  typedef enum logic [1:0] {IDLE, CAPT, ACCUM, OUT} state_t;

  state_t state, state_nxt;

  logic          sr_q;
  logic          rise;
  logic [9:0]    raw_x, raw_y;
  logic          raw_fire;
  logic [9:0]    lat_x, lat_y;
  logic          lat_fire;
  logic [9:0]    hist_x [N];
  logic [9:0]    hist_y [N];
  logic [SW-1:0] sum_x, sum_y;
  logic [9:0]    dz_x, dz_y;
  logic          stable;
  logic [2:0]    cnt;
  logic          do_latch, do_capt, do_accum, do_out;

  assign raw_x    = {jstk_data[25:24], jstk_data[39:32]};
  assign raw_y    = {jstk_data[9:8],   jstk_data[23:16]};
  assign raw_fire = jstk_data[1];

  // Remaining DOUT bits carry nothing this block consumes.
  logic unused_bits;
  assign unused_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:2], jstk_data[0]};

  // sr_q resets high so a request already asserted at reset release is ignored.
  assign rise = sndRec & ~sr_q;

  // Average of the accumulator, snapped to CENTER when strictly inside the deadzone.
  function automatic logic [9:0] deadzone(input logic [SW-1:0] sum);
    logic [9:0]         avg;
    logic signed [10:0] diff;
    logic [10:0]        mag;
    avg  = 10'(sum >> AVG_LOG2);
    diff = $signed({1'b0, avg}) - $signed({1'b0, CENTER_W});
    mag  = diff[10] ? $unsigned(-diff) : $unsigned(diff);
    return (mag < 11'(DEADZONE)) ? CENTER_W : avg;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = CAPT;
      CAPT:    state_nxt = ACCUM;
      ACCUM:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rises seen outside IDLE never reach do_latch, so they are simply dropped.
  always_comb begin
    do_latch = (state == IDLE) && rise;
    do_capt  = (state == CAPT);
    do_accum = (state == ACCUM);
    do_out   = (state == OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q     <= 1'b1;
      lat_x    <= CENTER_W;
      lat_y    <= CENTER_W;
      lat_fire <= 1'b0;
    end else begin
      sr_q <= sndRec;
      if (do_latch) begin
        lat_x    <= raw_x;
        lat_y    <= raw_y;
        lat_fire <= raw_fire;
      end
    end
  end

  // Running sums track the history contents, so no re-summing is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        hist_x[i] <= CENTER_W;
        hist_y[i] <= CENTER_W;
      end
      sum_x  <= SUM_RST;
      sum_y  <= SUM_RST;
      stable <= 1'b0;
      cnt    <= 3'd0;
    end else if (do_capt) begin
      sum_x     <= sum_x + SW'(lat_x) - SW'(hist_x[N-1]);
      sum_y     <= sum_y + SW'(lat_y) - SW'(hist_y[N-1]);
      hist_x[0] <= lat_x;
      hist_y[0] <= lat_y;
      for (int i = 1; i < N; i++) begin
        hist_x[i] <= hist_x[i-1];
        hist_y[i] <= hist_y[i-1];
      end
      if (lat_fire != stable) begin
        if (cnt == 3'(DEBOUNCE - 1)) begin
          stable <= ~stable;
          cnt    <= 3'd0;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else begin
        cnt <= 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_x <= CENTER_W;
      dz_y <= CENTER_W;
    end else if (do_accum) begin
      dz_x <= deadzone(sum_x);
      dz_y <= deadzone(sum_y);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos        <= CENTER_W;
      y_pos        <= CENTER_W;
      fire_level   <= 1'b0;
      fire_pulse   <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      fire_pulse   <= 1'b0;
      sample_valid <= 1'b0;
      if (do_out) begin
        x_pos        <= dz_x;
        y_pos        <= dz_y;
        fire_level   <= stable;
        fire_pulse   <= stable & ~fire_level;
        sample_valid <= 1'b1;
      end
    end
  end

endmodule
